// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a one-entry holding buffer.
// A frame is start, DATA_BITS data bits (LSB first), an optional parity bit
// and STOP_BITS stop bits. Each bit lasts BAUD_DIV clocks. The holding buffer
// lets a second byte wait while a frame is on the line, so frames can run
// back-to-back with no idle clocks between them.
module uart_tx_frame #(
    parameter int BAUD_DIV  = 104,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_line,
    output logic                 tx_busy
);

    localparam int              CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
    localparam bit              HAS_PAR   = (PARITY != 0);
    localparam bit              ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          baud_reg, baud_next;
    logic [2:0]             bit_reg, bit_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   parity_reg, parity_next;
    logic [DATA_BITS-1:0]   buf_reg, buf_next;
    logic                   buf_full_reg, buf_full_next;
    logic                   line_reg, line_next;

    logic                   bit_end;
    logic                   accept;

    // Parity is taken from the whole byte at load time, since the shifter
    // destroys the data while it is being sent.
    function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
        return ODD_PAR ? ~(^d) : (^d);
    endfunction

    assign bit_end  = (baud_reg == '0);
    assign accept   = tx_valid && !buf_full_reg;

    assign tx_ready = !buf_full_reg;
    assign tx_busy  = (state_reg != S_IDLE) || buf_full_reg;
    assign tx_line  = line_reg;

    // Next-state logic: bit timing, shifter, holding buffer and line level.
    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        buf_next      = buf_reg;
        buf_full_next = buf_full_reg;

        if (state_reg == S_IDLE) begin
            // From idle the byte bypasses the buffer and goes straight out.
            if (accept) begin
                state_next  = S_START;
                baud_next   = BAUD_LAST;
                bit_next    = '0;
                shift_next  = tx_data;
                parity_next = frame_parity(tx_data);
            end
        end else begin
            baud_next = bit_end ? BAUD_LAST : baud_reg - 1'b1;

            if (accept) begin
                buf_next      = tx_data;
                buf_full_next = 1'b1;
            end

            if (bit_end) begin
                case (state_reg)
                    S_START: begin
                        state_next = S_DATA;
                        bit_next   = '0;
                    end
                    S_DATA: begin
                        if (bit_reg == DATA_LAST) begin
                            state_next = HAS_PAR ? S_PARITY : S_STOP;
                            bit_next   = '0;
                        end else begin
                            bit_next   = bit_reg + 3'd1;
                            shift_next = shift_reg >> 1;
                        end
                    end
                    S_PARITY: begin
                        state_next = S_STOP;
                        bit_next   = '0;
                    end
                    S_STOP: begin
                        if (bit_reg == STOP_LAST) begin
                            if (buf_full_reg) begin
                                // Buffered byte follows with no idle gap.
                                state_next    = S_START;
                                bit_next      = '0;
                                shift_next    = buf_reg;
                                parity_next   = frame_parity(buf_reg);
                                buf_full_next = 1'b0;
                            end else if (accept) begin
                                // A byte arriving on the very last stop clock
                                // goes straight to the shifter rather than
                                // being stranded in the buffer while idle.
                                state_next    = S_START;
                                bit_next      = '0;
                                shift_next    = tx_data;
                                parity_next   = frame_parity(tx_data);
                                buf_full_next = 1'b0;
                            end else begin
                                state_next = S_IDLE;
                                baud_next  = '0;
                                bit_next   = '0;
                            end
                        end else begin
                            bit_next = bit_reg + 3'd1;
                        end
                    end
                    default: begin
                        state_next = S_IDLE;
                    end
                endcase
            end
        end

        // The line register is loaded with the level of the state being entered.
        case (state_next)
            S_START:  line_next = 1'b0;
            S_DATA:   line_next = shift_next[0];
            S_PARITY: line_next = parity_next;
            default:  line_next = 1'b1;
        endcase
    end

    // State and datapath registers; reset abandons any frame and buffered byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            buf_reg      <= '0;
            buf_full_reg <= 1'b0;
            line_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            buf_reg      <= buf_next;
            buf_full_reg <= buf_full_next;
            line_reg     <= line_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: four instances cover 8N1/div4, 7E2/div3,
// 7O2/div3 and 8N1/div2. Directed frames are compared clock-by-clock against
// waveforms expanded from hand-written frame bit patterns; a random stream is
// decoded by a bit-level UART receiver and compared with the bytes sent.
module tb_uart_tx_frame;

    logic clk;
    logic reset_n;

    logic [7:0] a_data;
    logic       a_valid, a_ready, a_line, a_busy;
    logic [6:0] b_data;
    logic       b_valid, b_ready, b_line, b_busy;
    logic [6:0] c_data;
    logic       c_valid, c_ready, c_line, c_busy;
    logic [7:0] d_data;
    logic       d_valid, d_ready, d_line, d_busy;

    int checks;
    int fails;

    uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .tx_line(a_line), .tx_busy(a_busy));

    uart_tx_frame #(.BAUD_DIV(3), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .tx_line(b_line), .tx_busy(b_busy));

    uart_tx_frame #(.BAUD_DIV(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .tx_data(c_data), .tx_valid(c_valid),
        .tx_ready(c_ready), .tx_line(c_line), .tx_busy(c_busy));

    uart_tx_frame #(.BAUD_DIV(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_d (
        .clk(clk), .reset_n(reset_n), .tx_data(d_data), .tx_valid(d_valid),
        .tx_ready(d_ready), .tx_line(d_line), .tx_busy(d_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit i = i-th level on the line (start first)
    } vec_t;

    vec_t vecs [6];

    logic [7:0] rnd_bytes [100];
    int         rx_count;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Clock-by-clock line waveform: each frame level held for div clocks,
    // idle high after the frame, up to total samples.
    function automatic logic [127:0] line_exp(input logic [15:0] frame, input int nbits,
                                              input int div, input int total);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < total; j++)
            r[j] = (j < nbits * div) ? frame[j / div] : 1'b1;
        return r;
    endfunction

    function automatic logic [127:0] busy_exp(input int len);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < len; j++) r[j] = 1'b1;
        return r;
    endfunction

    // One byte from idle on the 8N1/div4 instance, checked over 40 clocks plus end.
    task automatic send_and_check_a(input logic [7:0] data, input logic [9:0] frame, input string name);
        logic [127:0] cap_line, cap_busy;
        cap_line = '0;
        cap_busy = '0;
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = data;
        @(negedge clk);
        a_valid = 1'b0;
        a_data  = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            cap_line[i] = a_line;
            cap_busy[i] = a_busy;
            if (i < 39) @(negedge clk);
        end
        @(negedge clk);
        check({name, " line"}, cap_line, line_exp({6'b0, frame}, 10, 4, 40));
        check({name, " busy"}, cap_busy, busy_exp(40));
        check({name, " end busy/line"}, 128'({a_busy, a_line}), 128'(2'b01));
        $display("frame %s data %02h checked", name, data);
    endtask

    initial begin
        logic [127:0] cap_b, cap_c, cap_d, bsy_b, bsy_c, bsy_d;
        logic [127:0] cap_line, cap_ready, exp_line, exp_ready;

        checks  = 0;
        fails   = 0;
        reset_n = 1'b0;
        a_valid = 1'b0; a_data = '0;
        b_valid = 1'b0; b_data = '0;
        c_valid = 1'b0; c_data = '0;
        d_valid = 1'b0; d_data = '0;

        vecs[0] = '{8'h2E, 10'h25C};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'hA5, 10'h34A};
        vecs[4] = '{8'h01, 10'h202};
        vecs[5] = '{8'h80, 10'h300};

        // Reset held for three clocks.
        repeat (3) @(negedge clk);
        check("reset line", 128'(a_line), 128'(1'b1));
        check("reset ready", 128'(a_ready), 128'(1'b1));
        check("reset busy", 128'(a_busy), 128'(1'b0));
        check("reset line d", 128'({d_line, d_ready, d_busy}), 128'(3'b110));
        $display("reset state checked");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven 8N1 frames at BAUD_DIV = 4.
        for (int i = 0; i < 6; i++)
            send_and_check_a(vecs[i].data, vecs[i].frame, $sformatf("vec%0d", i));

        // 7E2 and 7O2 at div 3 with 0x41, and 8N1 at div 2 with 0xFF, together.
        cap_b = '0; cap_c = '0; cap_d = '0;
        bsy_b = '0; bsy_c = '0; bsy_d = '0;
        @(negedge clk);
        b_valid = 1'b1; b_data = 7'h41;
        c_valid = 1'b1; c_data = 7'h41;
        d_valid = 1'b1; d_data = 8'hFF;
        @(negedge clk);
        b_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0;
        for (int i = 0; i < 34; i++) begin
            cap_b[i] = b_line; bsy_b[i] = b_busy;
            cap_c[i] = c_line; bsy_c[i] = c_busy;
            cap_d[i] = d_line; bsy_d[i] = d_busy;
            if (i < 33) @(negedge clk);
        end
        check("7E2 line", cap_b, line_exp(16'h0682, 11, 3, 34));
        check("7E2 busy", bsy_b, busy_exp(33));
        check("7O2 line", cap_c, line_exp(16'h0782, 11, 3, 34));
        check("7O2 busy", bsy_c, busy_exp(33));
        check("div2 line", cap_d, line_exp(16'h03FE, 10, 2, 34));
        check("div2 busy", bsy_d, busy_exp(20));
        $display("7E2/7O2 data 41 and div2 data FF checked");

        // Back-to-back with tx_valid held: 0x55, 0xAA, then 0x33 under back-pressure.
        cap_line = '0;
        cap_ready = '0;
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 8'h55;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            cap_line[i]  = a_line;
            cap_ready[i] = a_ready;
            if (i == 0)  a_data  = 8'hAA;
            if (i == 1)  a_data  = 8'h33;
            if (i == 41) a_valid = 1'b0;
        end
        @(negedge clk);
        exp_line = line_exp(16'h02AA, 10, 4, 40)
                 | (line_exp(16'h0354, 10, 4, 40) << 40)
                 | (line_exp(16'h0266, 10, 4, 40) << 80);
        exp_ready = '0;
        for (int i = 0; i < 120; i++)
            exp_ready[i] = (i == 0) || (i == 40) || (i >= 80);
        check("b2b line", cap_line, exp_line);
        check("b2b ready", cap_ready, exp_ready);
        check("b2b end busy", 128'(a_busy), 128'(1'b0));
        $display("back-to-back 55 AA 33 checked");

        // Reset mid-DATA with a byte in the buffer, then a clean frame.
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 8'h00;
        @(negedge clk);
        a_data  = 8'h0F;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("pre-reset busy/ready/line", 128'({a_busy, a_ready, a_line}), 128'(3'b100));
        reset_n = 1'b0;
        #1;
        check("async reset line", 128'(a_line), 128'(1'b1));
        check("async reset busy/ready", 128'({a_busy, a_ready}), 128'(2'b01));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        check("post-reset idle", 128'({a_busy, a_line}), 128'(2'b01));
        $display("mid-frame reset checked");
        send_and_check_a(8'hA5, 10'h34A, "after reset");

        // Random stream with gaps and held valid, decoded by a line monitor.
        for (int i = 0; i < 100; i++) rnd_bytes[i] = 8'($urandom);
        rx_count = 0;
        @(negedge clk);
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    int w;
                    a_valid = 1'b1;
                    a_data  = rnd_bytes[n];
                    w = 0;
                    while (!a_ready && w < 200) begin
                        @(negedge clk);
                        w++;
                    end
                    check($sformatf("rand accept %0d", n), 128'(w < 200), 128'(1'b1));
                    @(negedge clk);
                    if ($urandom_range(0, 2) == 0) begin
                        a_valid = 1'b0;
                        a_data  = 8'($urandom);
                        repeat ($urandom_range(1, 50)) @(negedge clk);
                    end
                end
                a_valid = 1'b0;
            end
            begin
                int guard;
                logic [7:0] rx;
                logic start_lvl, stop_lvl;
                guard = 0;
                while (rx_count < 100 && guard < 30000) begin
                    @(negedge clk);
                    guard++;
                    if (a_line == 1'b0) begin
                        repeat (2) @(negedge clk);
                        start_lvl = a_line;
                        for (int j = 0; j < 8; j++) begin
                            repeat (4) @(negedge clk);
                            rx[j] = a_line;
                        end
                        repeat (4) @(negedge clk);
                        stop_lvl = a_line;
                        guard += 38;
                        check($sformatf("rx byte %0d", rx_count), 128'(rx), 128'(rnd_bytes[rx_count]));
                        check($sformatf("rx framing %0d", rx_count), 128'({start_lvl, stop_lvl}), 128'(2'b01));
                        $display("rx %0d: got %02h sent %02h", rx_count, rx, rnd_bytes[rx_count]);
                        rx_count++;
                    end
                end
                check("rx byte count", 128'(rx_count), 128'(100));
            end
        join
        repeat (60) @(negedge clk);
        check("final idle", 128'({a_busy, a_ready, a_line}), 128'(3'b011));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised, back-pressured UART transmitter: the successor to the fixed 8N1 transmit path, used wherever a core streams bytes out of a TXD pin. It adds configurable data width, parity, stop bits and baud divisor. A one-entry holding buffer behind a valid/ready handshake allows back-to-back frames with no idle gap between them. It sits between any byte producer (heartbeat, FIFO, command engine) and the external `tx_line`.

## Interface
- `BAUD_DIV`, 104: clocks per bit; 104 gives 115200 baud from 12 MHz. Legal range 2..65535.
- `DATA_BITS`, 8: data bits per frame, 5..8, sent LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `clk  input  1`: system clock. Everything is on the rising edge.
- `reset_n  input  1`: asynchronous, active-low reset.
- `tx_data  input  DATA_BITS`: byte to send, sampled on the handshake.
- `tx_valid  input  1`: producer has data.
- `tx_ready  output  1`: holding buffer empty, so the block can accept.
- `tx_line  output  1`: TXD, idle high.
- `tx_busy  output  1`: a frame is on the line or the buffer is occupied.

## Operation
- Handshake: a transfer occurs on a rising edge where `tx_valid && tx_ready`.
  - `tx_data` is captured on that edge.
  - Producer may hold `tx_valid` high indefinitely.
  - Data must be stable while `tx_valid` is high and `tx_ready` is low.
- Storage: a shifter plus a one-entry holding buffer. `tx_ready = !buffer_full`.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START: on a transfer, data loads directly into the shifter; the buffer stays empty.
  - START -> DATA: after 1 bit period.
  - DATA -> PARITY (PARITY != 0) or STOP: after DATA_BITS bit periods.
  - PARITY -> STOP: after 1 bit period.
  - STOP -> START if buffer full: buffer moves to the shifter on the last STOP clock, and the buffer empties.
  - STOP -> IDLE otherwise.
- Transfer while not IDLE: data goes to the buffer.
- Line levels:
  - START drives 0.
  - DATA drives shifter bit 0, shifting right each bit period.
  - PARITY drives the XOR of the data bits; inverted for odd parity.
  - STOP and IDLE drive 1.
- Parity is computed from the captured data at load, not from the shifting register.
- Baud counter: counts BAUD_DIV-1 down to 0 per bit and reloads on every bit boundary. Width is clog2(BAUD_DIV).
- Bit counter: counts data bits and stop bits. Width is 3 bits.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BAUD_DIV clocks exactly.
- `tx_line` is registered: no combinational path from inputs.
- `tx_busy = (state != IDLE) || buffer_full`.

## Timing
- Reset values: `tx_line = 1`, `tx_ready = 1`, `tx_busy = 0`, state IDLE, buffer empty, counters 0.
- Reset asserted mid-frame: `tx_line` goes to 1 immediately (asynchronously). The frame is abandoned and the buffered byte is discarded.
- Latency: transfer on edge k (from IDLE) makes `tx_line` low and `tx_busy` high in the cycle after edge k.
- `tx_ready` behaviour:
  - Falls the cycle after a transfer into the buffer.
  - Rises the cycle after the buffer is moved into the shifter.
- Same-edge events: a transfer on the same edge that the buffer empties is impossible, because `tx_ready` is low then. The next byte is accepted one cycle later.
- Back-to-back: the last STOP clock is immediately followed by the START low of the buffered frame. There is zero idle clocks between frames.
- End of frame: when IDLE is reached with the buffer empty, `tx_busy` falls in the cycle after the last STOP clock.
- `tx_valid` low: no state change. `tx_data` is ignored.

## Test plan
- Reset: hold `reset_n` low for 3 clocks -> `tx_line = 1`, `tx_ready = 1`, `tx_busy = 0`. Assert `reset_n` low mid-DATA -> `tx_line = 1` within the same cycle, and the next frame starts cleanly.
- 8N1 frame (BAUD_DIV = 4, defaults otherwise): send 0x2E -> line reads 0,0,1,1,1,0,1,0,0,1, each level exactly 4 clocks (40 clocks total). `tx_busy` falls after clock 40.
- 7E2 frame (DATA_BITS = 7, PARITY = 2, STOP_BITS = 2, BAUD_DIV = 3): send 0x41 -> start 0, data 1,0,0,0,0,0,1, parity 0, stop 1,1, 33 clocks total. Repeat with PARITY = 1 -> parity bit 1.
- Back-to-back (BAUD_DIV = 4): hold `tx_valid` high with 0x55 then 0xAA -> both accepted, `tx_ready` low during the first frame, and the second start bit begins on the clock after the first frame's final stop clock (80 clocks contiguous).
- Back-pressure: assert a third `tx_valid` while the buffer is full -> not accepted until `tx_ready` rises. No byte lost or duplicated across 100 random bytes, checked by a bit-level line monitor.
- Minimum divisor: BAUD_DIV = 2 with 8N1, send 0xFF -> 10 levels of 2 clocks each, start bit 0 then nine 1s.
